// File: rtl/tdp_ram_param.sv
// Parametrised true dual-port RAM with byte enables, read-during-write mode
// select, collision flag and post-reset clear. Option: TDP_RAM_OUT_REG_EN.
//
// state    | meaning
// ST_CLEAR | zeroing memory one word per cycle, ports ignored
// ST_READY | normal dual-port operation until the next reset
module tdp_ram_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   data_a,
  output logic [DATA_W-1:0]   q_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic [DATA_W-1:0]   q_b,
  output logic                init_busy,
  output logic                collision
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                init_busy_q, init_busy_d;
  logic [DATA_W-1:0]   q_a_q, q_a_d;
  logic [DATA_W-1:0]   q_b_q, q_b_d;
  logic                collision_q, collision_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready, wr_a, wr_b, same_addr;
  logic [NB-1:0]       lane_a, lane_b;
  logic [DATA_W-1:0]   old_a, old_b, new_a, new_b;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    ready     = (state_q == ST_READY);
    wr_a      = ready & en_a & we_a;
    wr_b      = ready & en_b & we_b;
    same_addr = (addr_a == addr_b);
    lane_a    = wr_a ? be_a : '0;
    // Port A owns any lane both ports write at the same address.
    lane_b    = wr_b ? (be_b & ~((wr_a && same_addr) ? be_a : '0)) : '0;
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    new_a     = merge_lanes(old_a, data_a, be_a);
    new_b     = merge_lanes(old_b, data_b, be_b);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_busy_d = init_busy_q;
    q_a_d       = q_a_q;
    q_b_d       = q_b_q;
    collision_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d     = ST_READY;
          init_busy_d = 1'b0;
        end
      end
      ST_READY: begin
        if (en_a) q_a_d = (we_a && RDW_MODE == 0) ? new_a : old_a;
        if (en_b) q_b_d = (we_b && RDW_MODE == 0) ? new_b : old_b;
        collision_d = en_a & en_b & same_addr & (we_a | we_b);
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      init_busy_q <= 1'b1;
      q_a_q       <= '0;
      q_b_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_busy_q <= init_busy_d;
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      collision_q <= collision_d;
    end
  end

  // Storage has no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem[ptr_q] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (lane_a[i]) mem[addr_a][i*8 +: 8] <= data_a[i*8 +: 8];
          if (lane_b[i]) mem[addr_b][i*8 +: 8] <= data_b[i*8 +: 8];
        end
      end
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [DATA_W-1:0] q_a_p_q, q_a_p_d, q_b_p_q, q_b_p_d;
  logic              collision_p_q, collision_p_d;

  always_comb begin
    rd_a_d        = ready & en_a;
    rd_b_d        = ready & en_b;
    q_a_p_d       = rd_a_q ? q_a_q : q_a_p_q;
    q_b_p_d       = rd_b_q ? q_b_q : q_b_p_q;
    collision_p_d = collision_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_a_q        <= 1'b0;
      rd_b_q        <= 1'b0;
      q_a_p_q       <= '0;
      q_b_p_q       <= '0;
      collision_p_q <= 1'b0;
    end else begin
      rd_a_q        <= rd_a_d;
      rd_b_q        <= rd_b_d;
      q_a_p_q       <= q_a_p_d;
      q_b_p_q       <= q_b_p_d;
      collision_p_q <= collision_p_d;
    end
  end

  assign q_a       = q_a_p_q;
  assign q_b       = q_b_p_q;
  assign collision = collision_p_q;
`else
  assign q_a       = q_a_q;
  assign q_b       = q_b_q;
  assign collision = collision_q;
`endif

  assign init_busy = init_busy_q;

endmodule
